// File: rtl/mem_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_seq_ctrl_if
// Description : Host write/read streams plus the memory bus of mem_seq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_seq_ctrl_if #(
    parameter int AW = 3,
    parameter int DW = 8
);
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_start;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW:0]   count;
    logic          busy;
    logic [DW-1:0] mem_i;
    logic [AW-1:0] mem_adr;
    logic          mem_op;
    logic          mem_select;
    logic [DW-1:0] mem_o;

    // master: the surrounding host plus memory; slave: the controller itself
    modport master (
        output wr_valid, wr_data, rd_start, rd_ready, mem_o,
        input  wr_ready, rd_data, rd_valid, count, busy,
               mem_i, mem_adr, mem_op, mem_select
    );

    modport slave (
        input  wr_valid, wr_data, rd_start, rd_ready, mem_o,
        output wr_ready, rd_data, rd_valid, count, busy,
               mem_i, mem_adr, mem_op, mem_select
    );
endinterface
`default_nettype wire

// File: rtl/mem_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_seq_ctrl
// Description : Stores up to DEPTH host bytes in an external memory, then
//               streams them back in order on command and empties itself.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_seq_ctrl #(
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int DW     = 8,
    parameter int WR_CYC = 2,
    parameter int RD_LAT = 1
) (
    input  wire logic    clk,
    input  wire logic    rst,
    mem_seq_ctrl_if.slave bus
);
    localparam int          CW      = (WR_CYC > RD_LAT) ? $clog2(WR_CYC + 1) : $clog2(RD_LAT + 1);
    localparam logic [AW:0] c_depth = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_RD_ADDR = 3'd2,
        S_RD_WAIT = 3'd3,
        S_RD_OUT  = 3'd4
    } state_t;

    state_t        r_state,    w_state;
    logic [AW:0]   r_count,    w_count;
    logic [AW-1:0] r_wr_ptr,   w_wr_ptr;
    logic [AW-1:0] r_rd_ptr,   w_rd_ptr;
    logic [CW-1:0] r_cyc,      w_cyc;
    logic [DW-1:0] r_rd_data,  w_rd_data;
    logic          r_rd_valid, w_rd_valid;
    logic [DW-1:0] r_mem_i,    w_mem_i;
    logic [AW-1:0] r_mem_adr,  w_mem_adr;
    logic          r_mem_op,   w_mem_op;
    logic          r_mem_sel,  w_mem_sel;
    logic          w_wr_ready;

    assign w_wr_ready = (r_state == S_IDLE) && (r_count < c_depth) && !bus.rd_start;

    always_comb begin
        w_state    = r_state;
        w_count    = r_count;
        w_wr_ptr   = r_wr_ptr;
        w_rd_ptr   = r_rd_ptr;
        w_cyc      = r_cyc;
        w_rd_data  = r_rd_data;
        w_rd_valid = r_rd_valid;
        w_mem_i    = r_mem_i;
        w_mem_adr  = r_mem_adr;
        w_mem_op   = r_mem_op;
        w_mem_sel  = r_mem_sel;
        case (r_state)
            S_IDLE: begin
                w_mem_op  = 1'b0;
                w_mem_sel = 1'b0;
                // A read request wins over a simultaneous write; an empty read is dropped
                if (bus.rd_start) begin
                    if (r_count != '0) begin
                        w_state  = S_RD_ADDR;
                        w_rd_ptr = '0;
                    end
                end else if (bus.wr_valid && w_wr_ready) begin
                    w_state   = S_WRITE;
                    w_mem_i   = bus.wr_data;
                    w_mem_adr = r_wr_ptr;
                    w_mem_op  = 1'b1;
                    w_mem_sel = 1'b1;
                    w_cyc     = CW'(WR_CYC - 1);
                end
            end
            S_WRITE: begin
                if (r_cyc == '0) begin
                    w_mem_op  = 1'b0;
                    w_mem_sel = 1'b0;
                    w_wr_ptr  = r_wr_ptr + 1'b1;
                    w_count   = r_count + 1'b1;
                    w_state   = S_IDLE;
                end else begin
                    w_cyc = r_cyc - 1'b1;
                end
            end
            S_RD_ADDR: begin
                w_mem_adr = r_rd_ptr;
                w_mem_op  = 1'b0;
                w_mem_sel = 1'b1;
                w_cyc     = CW'(RD_LAT);
                w_state   = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (r_cyc == '0) begin
                    w_rd_data  = bus.mem_o;
                    w_rd_valid = 1'b1;
                    w_state    = S_RD_OUT;
                end else begin
                    w_cyc = r_cyc - 1'b1;
                end
            end
            S_RD_OUT: begin
                if (bus.rd_ready) begin
                    w_rd_valid = 1'b0;
                    if ({1'b0, r_rd_ptr} == r_count - 1'b1) begin
                        w_mem_sel = 1'b0;
                        w_count   = '0;
                        w_wr_ptr  = '0;
                        w_state   = S_IDLE;
                    end else begin
                        w_rd_ptr = r_rd_ptr + 1'b1;
                        w_state  = S_RD_ADDR;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cyc      <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_mem_i    <= '0;
            r_mem_adr  <= '0;
            r_mem_op   <= 1'b0;
            r_mem_sel  <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_count    <= w_count;
            r_wr_ptr   <= w_wr_ptr;
            r_rd_ptr   <= w_rd_ptr;
            r_cyc      <= w_cyc;
            r_rd_data  <= w_rd_data;
            r_rd_valid <= w_rd_valid;
            r_mem_i    <= w_mem_i;
            r_mem_adr  <= w_mem_adr;
            r_mem_op   <= w_mem_op;
            r_mem_sel  <= w_mem_sel;
        end
    end

    assign bus.wr_ready   = w_wr_ready;
    assign bus.rd_data    = r_rd_data;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.count      = r_count;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.mem_i      = r_mem_i;
    assign bus.mem_adr    = r_mem_adr;
    assign bus.mem_op     = r_mem_op;
    assign bus.mem_select = r_mem_sel;
endmodule
`default_nettype wire

// File: tb/tb_mem_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_seq_ctrl
// Description : Scoreboard bench for mem_seq_ctrl with a behavioural 8x8 memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_seq_ctrl;
    localparam int DEPTH  = 8;
    localparam int AW     = 3;
    localparam int DW     = 8;
    localparam int WR_CYC = 2;
    localparam int RD_LAT = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_seq_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    mem_seq_ctrl #(
        .DEPTH(DEPTH), .AW(AW), .DW(DW), .WR_CYC(WR_CYC), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Memory with a registered read port
    logic [DW-1:0] mem_arr [DEPTH];
    logic [DW-1:0] mem_o_r;
    always @(posedge clk) begin
        if (bus.mem_select && bus.mem_op)  mem_arr[bus.mem_adr] <= bus.mem_i;
        if (bus.mem_select && !bus.mem_op) mem_o_r <= mem_arr[bus.mem_adr];
    end
    assign bus.mem_o = mem_o_r;

    int checks   = 0;
    int failures = 0;
    int stored   = 0;
    logic [DW-1:0]    sb [$];
    logic [AW+DW-1:0] wq [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every write strobe must match the queued address/data and last WR_CYC cycles
    int               slen = 0;
    logic [AW+DW-1:0] sexp;
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            slen = 0;
            wq.delete();
        end else if (bus.mem_op && bus.mem_select) begin
            if (slen == 0) begin
                check_eq("wr_strobe_queued", 32'(wq.size() > 0), 1);
                if (wq.size() > 0) sexp = wq.pop_front();
            end
            check_eq("wr_strobe_bus", {bus.mem_adr, bus.mem_i}, sexp);
            slen++;
        end else if (slen != 0) begin
            check_eq("wr_strobe_len", slen, WR_CYC);
            slen = 0;
        end
    end

    task automatic wr_byte(input logic [DW-1:0] b);
        bit ok;
        ok = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = b;
        for (int n = 0; n < 20 && !ok; n++) begin
            #1;
            if (bus.wr_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.wr_valid = 1'b0;
        check_eq("wr_accept", 32'(ok), 1);
        if (ok) begin
            sb.push_back(b);
            wq.push_back({AW'(stored), b});
            stored++;
        end
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 50 && bus.busy; n++) begin
            @(posedge clk);
            #1;
        end
        check_eq("idle_reached", 32'(bus.busy), 0);
    endtask

    // mode 0: rd_ready always high; mode 1: one cycle high, three low
    task automatic rd_all(input int mode, input bit with_wr);
        int n_exp;
        int lat;
        int got;
        n_exp = sb.size();
        bus.rd_start = 1'b1;
        if (with_wr) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 8'hEE;
            #1;
            check_eq("wr_ready_rd_prio", 32'(bus.wr_ready), 0);
        end
        @(posedge clk);
        #1;
        bus.rd_start = 1'b0;
        bus.wr_valid = 1'b0;
        if (with_wr) check_eq("count_hold", bus.count, n_exp);
        lat = 0;
        while (!bus.rd_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("rd_first_latency", lat, RD_LAT + 2);
        got = 0;
        for (int t = 0; t < 400 && got < n_exp; t++) begin
            bus.rd_ready = (mode == 0) ? 1'b1 : ((t % 4) == 0);
            #1;
            if (bus.rd_valid) begin
                check_eq("rd_data", bus.rd_data, sb[0]);
                if (bus.rd_ready) begin
                    void'(sb.pop_front());
                    got++;
                end
            end
            @(posedge clk);
            #1;
        end
        bus.rd_ready = 1'b0;
        check_eq("rd_byte_count", got, n_exp);
        check_eq("drain_state", {bus.busy, bus.mem_select, bus.rd_valid, bus.count}, 0);
        for (int t = 0; t < 3; t++) begin
            @(posedge clk);
            #1;
            check_eq("rd_no_extra", 32'(bus.rd_valid), 0);
        end
        stored = 0;
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        stored = 0;
    endtask

    logic [DW-1:0] msg [8] = '{8'h4C, 8'h53, 8'h20, 8'h53, 8'h57, 8'h4B, 8'h20, 8'h21};

    initial begin
        rst          = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_start = 1'b0;
        bus.rd_ready = 1'b0;
        #12;
        check_eq("reset_wr_ready", 32'(bus.wr_ready), 1);
        check_eq("reset_outputs", {bus.rd_valid, bus.rd_data, bus.busy, bus.mem_i,
                                   bus.mem_adr, bus.mem_op, bus.mem_select, bus.count}, 0);
        release_rst();

        // Full message then in-order readback
        foreach (msg[i]) wr_byte(msg[i]);
        wait_idle();
        check_eq("count_full", bus.count, 8);
        rd_all(0, 1'b0);

        // Throttled readback
        foreach (msg[i]) if (i < 4) wr_byte(8'h30 + 8'(i));
        wait_idle();
        rd_all(1, 1'b0);

        // Writes refused when full
        for (int i = 0; i < 8; i++) wr_byte(8'h11 * 8'(i + 1));
        wait_idle();
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("full_wr_ready", 32'(bus.wr_ready), 0);
            check_eq("full_count", bus.count, 8);
            @(posedge clk);
            #1;
        end
        bus.wr_valid = 1'b0;
        rd_all(0, 1'b0);

        // Empty read is ignored; read beats a same-cycle write
        bus.rd_start = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("empty_start", {bus.busy, bus.mem_select, bus.rd_valid}, 0);
            @(posedge clk);
            #1;
        end
        wr_byte(8'h61); wr_byte(8'h62); wr_byte(8'h63);
        wait_idle();
        rd_all(0, 1'b1);

        // Async reset mid-write of byte 5
        for (int i = 0; i < 5; i++) wr_byte(8'h70 + 8'(i));
        #1;
        rst = 1'b1;
        #1;
        check_eq("rst_mid_write", {bus.mem_op, bus.mem_select, bus.rd_valid, bus.busy, bus.count}, 0);
        release_rst();

        // Async reset while a byte is presented
        wr_byte(8'h81); wr_byte(8'h82);
        wait_idle();
        bus.rd_start = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_start = 1'b0;
        for (int n = 0; n < 20 && !bus.rd_valid; n++) begin
            @(posedge clk);
            #1;
        end
        check_eq("rd_out_reached", 32'(bus.rd_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_mid_rd_out", {bus.mem_op, bus.mem_select, bus.rd_valid, bus.busy, bus.count}, 0);
        release_rst();
        wr_byte(8'h11); wr_byte(8'h22);
        wait_idle();
        rd_all(0, 1'b0);

        // Second message restarts at address 0
        wr_byte(8'hA1); wr_byte(8'hA2); wr_byte(8'hA3);
        wait_idle();
        rd_all(0, 1'b0);
        wr_byte(8'hB1);
        wait_idle();
        check_eq("count_one", bus.count, 1);
        rd_all(0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule
`default_nettype wire
